offchip_line_memory: RTL and testbench
======================================

Name: offchip_line_memory

Overview:
- Off-chip data memory serving the pipelined CPU's data cache on cache misses and write-backs.
- Holds 512 lines of 256 bits (16 KB).
- Each request (one line read or one line write) completes after a fixed multi-cycle latency and is signalled by a one-cycle acknowledge.
- The CPU's D-cache is the only master.

Parameters:
- LATENCY, 10: clock edges from request acceptance to the ack_o pulse; minimum 2.
- DEPTH, 512: number of lines.
- LINE_W, 256: line width in bits.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- addr_i  input  32  byte address; line index = addr_i[13:5], i.e. modulo DEPTH; addr_i[4:0] ignored.
- data_i  input  256  write line data.
- enable_i  input  1  request strobe.
- write_i  input  1  1 = line write, 0 = line read.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data; valid only while ack_o=1.

Behaviour:
- Storage: array `memory[0:DEPTH-1]` of LINE_W bits. The name is fixed because benches preload and inspect it hierarchically. Reset does not clear it.
- Reset (async, rst_i=1): state=IDLE, counter=0, ack_o=0, data_o=0, latched request cleared.
- IDLE:
  - If enable_i=1 at a rising edge, latch addr index, data_i and write_i, clear the counter, and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Counter increments each edge.
  - addr_i, data_i, write_i and enable_i are ignored; a dropped enable_i does not abort the request.
  - On the edge where the counter reaches LATENCY-1, assert ack_o (registered) for exactly one cycle and go to IDLE.
  - ack_o therefore rises LATENCY edges after the accepting edge.
- Read completion: data_o = memory[latched index] during the ack cycle; data_o=0 at all other times.
- Write completion: memory[latched index] <= latched data on the same edge that asserts ack_o. data_o stays 0.
- Back-to-back requests:
  - The ack cycle is spent in IDLE.
  - If enable_i is still high during the ack cycle, a new request is accepted on the next edge.
  - The master must deassert enable_i in the ack cycle to avoid a duplicate request.
  - Minimum spacing between acks is therefore LATENCY+1 cycles.
- Read-after-write to the same line returns the newly written data.
- Reset during WAIT: the request is dropped, no ack is issued, and memory is not modified.
- Index wrap: addresses at or above 0x4000 alias to line (addr_i>>5) mod DEPTH.

Optional Feature:
- Macro DMEM_PERF_EN.
- When defined, two extra outputs are added:
  - rd_cnt_o (32-bit): increments on every read ack.
  - wr_cnt_o (32-bit): increments on every write ack.
- Both counters reset to 0 on rst_i and saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Read latency and data:
  - Preload memory[0] = 0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF.
  - Stimulus: enable_i=1, write_i=0, addr_i=0x0000_0000.
  - Required: ack_o high exactly on the 10th edge after acceptance, for one cycle, with data_o equal to that line; data_o=0 before and after.
- Write then read back:
  - Stimulus: write addr_i=0x0400, data_i=…_1001_2002…F00F.
  - Required after ack: memory[32] equals that value, memory[31] and memory[33] are unchanged, and a following read of 0x0400 returns the same value.
- Input stability in WAIT:
  - Stimulus: read 0x0020; during WAIT change addr_i to 0x0040 and drop enable_i.
  - Required: ack_o still arrives at edge 10 with memory[1] (8888_9999…1111_0000).
- Reset mid-request:
  - Stimulus: write to 0x0200 and assert rst_i 5 cycles later.
  - Required: ack_o stays 0, memory[16] is unchanged, and the state returns to IDLE immediately.
- Aliasing and offset:
  - Stimulus: read addr_i=0x0000_401F.
  - Required: returns memory[0].
- Back-to-back with enable_i held high:
  - Required: two acks 11 cycles apart.
  - With DMEM_PERF_EN defined, rd_cnt_o = 2 after both.

Source files
------------

// File: rtl/offchip_line_memory_if.sv
// Request/response bus between the D-cache (master) and offchip_line_memory (slave).
// Optional DMEM_PERF_EN adds the read/write completion counters.
`default_nettype none

interface offchip_line_memory_if #(
  parameter int LINE_W = 256
);
  logic [31:0]       addr_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              ack_o;
  logic [LINE_W-1:0] data_o;
`ifdef DMEM_PERF_EN
  logic [31:0]       rd_cnt_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o, rd_cnt_o, wr_cnt_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o, rd_cnt_o, wr_cnt_o
  );
`else
  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );
  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );
`endif
endinterface

`default_nettype wire

// File: rtl/offchip_line_memory.sv
// offchip_line_memory: fixed-latency line memory (DEPTH x LINE_W) serving D-cache misses/write-backs.
// Optional macro DMEM_PERF_EN adds saturating read/write ack counters.
`default_nettype none

module offchip_line_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int LINE_W  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  offchip_line_memory_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  if (LATENCY < 2) begin : g_bad_latency
    $error("offchip_line_memory: LATENCY must be at least 2");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_data;
  logic              req_write;
  logic              ack;
  logic [LINE_W-1:0] rdata;

  logic [LINE_W-1:0] memory [0:DEPTH-1];

  logic [IDX_W-1:0]  addr_idx;
  logic              done;
  logic              unused_addr_bits;

  // Byte offset and bits above the line index are don't-care (addresses alias modulo DEPTH).
  assign addr_idx         = bus.addr_i[5 +: IDX_W];
  assign unused_addr_bits = ^{bus.addr_i[31:5+IDX_W], bus.addr_i[4:0]};
  assign done             = (state == WAIT) && (counter == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      counter   <= '0;
      req_idx   <= '0;
      req_data  <= '0;
      req_write <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
    end else begin
      ack   <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (bus.enable_i) begin
            req_idx   <= addr_idx;
            req_data  <= bus.data_i;
            req_write <= bus.write_i;
            counter   <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          counter <= counter + 1'b1;
          if (done) begin
            ack     <= 1'b1;
            counter <= '0;
            state   <= IDLE;
            if (!req_write) begin
              rdata <= memory[req_idx];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; an async reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk_i) begin
    if (done && req_write) begin
      memory[req_idx] <= req_data;
    end
  end

  assign bus.ack_o  = ack;
  assign bus.data_o = rdata;

`ifdef DMEM_PERF_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (done) begin
      if (!req_write && (rd_cnt != 32'hFFFF_FFFF)) begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (req_write && (wr_cnt != 32'hFFFF_FFFF)) begin
        wr_cnt <= wr_cnt + 32'd1;
      end
    end
  end

  assign bus.rd_cnt_o = rd_cnt;
  assign bus.wr_cnt_o = wr_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_offchip_line_memory.sv
// Randomized self-checking bench for offchip_line_memory against an array-based line model.
`default_nettype none

module tb_offchip_line_memory;
  localparam int LATENCY = 10;
  localparam int DEPTH   = 512;
  localparam int LINE_W  = 256;

  localparam logic [LINE_W-1:0] LINE0 =
    256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
  localparam logic [LINE_W-1:0] LINE1 =
    256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [LINE_W-1:0] WLINE =
    256'h0000_1001_2002_3003_4004_5005_6006_7007_8008_9009_A00A_B00B_C00C_D00D_E00E_F00F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  offchip_line_memory_if #(.LINE_W(LINE_W)) bus ();

  offchip_line_memory #(
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  logic [LINE_W-1:0] model [DEPTH];
  int errors = 0;
  int checks = 0;
  int rd_model = 0;
  int wr_model = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] addr);
    return int'((addr >> 5) % DEPTH);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete request; checks ack/data on every edge from acceptance to one past the ack.
  task automatic run_req(input bit wr, input logic [31:0] addr, input logic [LINE_W-1:0] wdata,
                         input bit disturb, input string tag);
    int idx;
    logic [LINE_W-1:0] exp_rd;
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = wr;
    bus.addr_i   = addr;
    bus.data_i   = wdata;
    @(posedge clk); #1;
    idx    = idx_of(addr);
    exp_rd = model[idx];
    bus.enable_i = 1'b0;
    if (disturb) begin
      bus.addr_i  = $urandom;
      bus.data_i  = rand_line();
      bus.write_i = ~wr;
    end
    check({tag, "_ack_e0"}, bus.ack_o, '0);
    for (int e = 1; e <= LATENCY + 1; e++) begin
      @(posedge clk); #1;
      check($sformatf("%s_ack_e%0d", tag, e), bus.ack_o, (e == LATENCY) ? 1 : 0);
      check($sformatf("%s_data_e%0d", tag, e), bus.data_o, (e == LATENCY && !wr) ? exp_rd : '0);
      if (disturb) bus.enable_i = (e >= 2 && e <= LATENCY - 2);
    end
    bus.enable_i = 1'b0;
    if (wr) begin
      model[idx] = wdata;
      wr_model++;
    end else begin
      rd_model++;
    end
  endtask

  task automatic back_to_back(input logic [31:0] addr);
    int first, second, idx;
    first  = -1;
    second = -1;
    idx    = idx_of(addr);
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b0;
    bus.addr_i   = addr;
    @(posedge clk); #1;
    for (int e = 1; e <= 2 * LATENCY + 5; e++) begin
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) begin
        check($sformatf("b2b_data_e%0d", e), bus.data_o, model[idx]);
        if (first < 0) first = e;
        else if (second < 0) begin
          second = e;
          bus.enable_i = 1'b0;
        end
      end
    end
    bus.enable_i = 1'b0;
    check("b2b_first_ack_edge", first, LATENCY);
    check("b2b_second_ack_edge", second, 2 * LATENCY + 1);
    rd_model += 2;
    if (second < 0) repeat (LATENCY + 2) @(posedge clk);
  endtask

  initial begin
    logic [LINE_W-1:0] d;
    logic [31:0] a;
    bit wr;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = rand_line();
    model[0] = LINE0;
    model[1] = LINE1;
    for (int i = 0; i < DEPTH; i++) dut.memory[i] = model[i];

    #12;
    check("reset_ack", bus.ack_o, '0);
    check("reset_data", bus.data_o, '0);
`ifdef DMEM_PERF_EN
    check("reset_rd_cnt", bus.rd_cnt_o, '0);
    check("reset_wr_cnt", bus.wr_cnt_o, '0);
`endif
    @(negedge clk) rst = 1'b0;

    run_req(1'b0, 32'h0000_0000, '0, 1'b0, "read0");
    run_req(1'b1, 32'h0000_0400, WLINE, 1'b0, "write32");
    check("mem32_after_write", dut.memory[32], WLINE);
    check("mem31_untouched", dut.memory[31], model[31]);
    check("mem33_untouched", dut.memory[33], model[33]);
    run_req(1'b0, 32'h0000_0400, '0, 1'b0, "readback32");
    run_req(1'b0, 32'h0000_0020, '0, 1'b1, "wait_stability");

    // Reset five edges into a write to line 16: no ack, no memory update.
    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 32'h0000_0200;
    bus.data_i   = ~model[16];
    @(posedge clk); #1;
    bus.enable_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midreset_ack", bus.ack_o, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rd_model = 0;
    wr_model = 0;
    for (int e = 0; e < LATENCY + 3; e++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset_ack_e%0d", e), bus.ack_o, '0);
    end
    check("mem16_unchanged", dut.memory[16], model[16]);

    back_to_back(32'h0000_00A0);
`ifdef DMEM_PERF_EN
    check("b2b_rd_cnt", bus.rd_cnt_o, 2);
`endif
    run_req(1'b0, 32'h0000_0200, '0, 1'b0, "readback16");
    run_req(1'b0, 32'h0000_401F, '0, 1'b0, "alias0");

    for (int n = 0; n < 40; n++) begin
      wr = ($urandom_range(0, 1) == 1);
      a  = (n % 4 == 0) ? 32'h0000_0400 : $urandom;
      d  = rand_line();
      run_req(wr, a, d, ($urandom_range(0, 3) == 0), $sformatf("rand%0d", n));
    end

`ifdef DMEM_PERF_EN
    check("final_rd_cnt", bus.rd_cnt_o, rd_model);
    check("final_wr_cnt", bus.wr_cnt_o, wr_model);
`endif
    for (int i = 0; i < DEPTH; i += 37) check($sformatf("final_mem%0d", i), dut.memory[i], model[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
